// File: rtl/ctrl_pkg.sv
// Shared decode constants, the control bundle carried through the decode queue,
// and the issue-state encoding.
package ctrl_pkg;

    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_FL      = 7'b0000111;
    localparam logic [6:0] OPC_FENCE   = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_FS      = 7'b0100111;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_FMADD   = 7'b1000011;
    localparam logic [6:0] OPC_FMSUB   = 7'b1000111;
    localparam logic [6:0] OPC_FNMSUB  = 7'b1001011;
    localparam logic [6:0] OPC_FNMADD  = 7'b1001111;
    localparam logic [6:0] OPC_FOTHER  = 7'b1010011;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

    localparam logic [4:0] ALU_ADD   = 5'd0;
    localparam logic [4:0] ALU_SUB   = 5'd1;
    localparam logic [4:0] ALU_SLL   = 5'd2;
    localparam logic [4:0] ALU_SLT   = 5'd3;
    localparam logic [4:0] ALU_SLTU  = 5'd4;
    localparam logic [4:0] ALU_XOR   = 5'd5;
    localparam logic [4:0] ALU_SRL   = 5'd6;
    localparam logic [4:0] ALU_SRA   = 5'd7;
    localparam logic [4:0] ALU_OR    = 5'd8;
    localparam logic [4:0] ALU_AND   = 5'd9;
    localparam logic [4:0] ALU_EQ    = 5'd10;
    localparam logic [4:0] ALU_PASSB = 5'd11;
    localparam logic [4:0] ALU_FP    = 5'd12;

    localparam logic [1:0] IMM_I = 2'd0;
    localparam logic [1:0] IMM_S = 2'd1;
    localparam logic [1:0] IMM_B = 2'd2;
    localparam logic [1:0] IMM_U = 2'd3;

    localparam logic [1:0] PC_KIND_PLUS4  = 2'd0;
    localparam logic [1:0] PC_KIND_BRANCH = 2'd1;
    localparam logic [1:0] PC_KIND_JAL    = 2'd2;
    localparam logic [1:0] PC_KIND_JALR   = 2'd3;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic [4:0] alu_op;
        logic       has_imm;
        logic [1:0] imm_type;
        logic [1:0] pc_kind;
        logic       is_load;
        logic       is_store;
        logic       is_branch;
        logic       is_jump;
        logic       is_system;
        logic       is_fence;
        logic       illegal;
        logic [2:0] br_funct3;
        logic       has_rs1;
        logic       has_rs2;
        logic       has_rs3;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rs3;
    } ctrl_t;

    typedef enum logic [1:0] {ST_RUN, ST_SERIAL, ST_HALT} fsm_t;

    // alt selects SUB/SRA (inst[30]) where the funct3 slot has two flavours.
    function automatic logic [4:0] alu_of(input logic [2:0] funct3, input logic alt);
        case (funct3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/inst_decoder.sv
// Combinational instruction -> control bundle decoder used at enqueue time.
// Illegal encodings collapse to an all-zero bundle with only illegal set.
module inst_decoder
    import ctrl_pkg::*;
#(
    parameter int INST_WIDTH = 32,
    parameter bit ENABLE_FP  = 1'b1
) (
    input  logic [INST_WIDTH-1:0] inst,
    output ctrl_t                 ctrl
);

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    ctrl_t      c;
    logic       bad;

    assign opc = inst[6:0];
    assign f3  = inst[14:12];
    assign f7  = inst[31:25];

    always_comb begin
        c         = '0;
        bad       = 1'b0;
        c.rd      = inst[11:7];
        c.rs1     = inst[19:15];
        c.rs2     = inst[24:20];
        c.rs3     = inst[31:27];
        c.has_rs1 = 1'b1;
        case (opc)
            OPC_LOAD: begin
                c.reg_write = 1'b1; c.mem_read = 1'b1; c.is_load = 1'b1;
                c.has_imm = 1'b1; c.imm_type = IMM_I;
            end
            OPC_STORE: begin
                c.mem_write = 1'b1; c.is_store = 1'b1; c.has_rs2 = 1'b1;
                c.has_imm = 1'b1; c.imm_type = IMM_S;
            end
            OPC_BRANCH: begin
                c.pc_kind = PC_KIND_BRANCH; c.alu_op = ALU_EQ; c.br_funct3 = f3;
                c.is_branch = 1'b1; c.has_rs2 = 1'b1; c.has_imm = 1'b1; c.imm_type = IMM_B;
            end
            OPC_JAL: begin
                c.reg_write = 1'b1; c.pc_kind = PC_KIND_JAL; c.is_jump = 1'b1; c.has_rs1 = 1'b0;
            end
            OPC_JALR: begin
                c.reg_write = 1'b1; c.pc_kind = PC_KIND_JALR; c.is_jump = 1'b1;
                c.has_imm = 1'b1; c.imm_type = IMM_I;
            end
            OPC_LUI: begin
                c.reg_write = 1'b1; c.alu_op = ALU_PASSB; c.has_rs1 = 1'b0;
                c.has_imm = 1'b1; c.imm_type = IMM_U;
            end
            OPC_AUIPC: begin
                c.reg_write = 1'b1; c.has_rs1 = 1'b0; c.has_imm = 1'b1; c.imm_type = IMM_U;
            end
            OPC_OP_IMM: begin
                c.reg_write = 1'b1; c.has_imm = 1'b1; c.imm_type = IMM_I;
                c.alu_op = alu_of(f3, inst[30] && (f3 == 3'b101));
                if (f3 == 3'b001 && f7 != 7'h00) bad = 1'b1;
                if (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20) bad = 1'b1;
            end
            OPC_OP: begin
                c.reg_write = 1'b1; c.has_rs2 = 1'b1; c.alu_op = alu_of(f3, inst[30]);
                if (f7 != 7'h00 && f7 != 7'h20) bad = 1'b1;
                if (f7 == 7'h20 && f3 != 3'b000 && f3 != 3'b101) bad = 1'b1;
            end
            OPC_FENCE: begin
                c.is_fence = 1'b1; c.has_rs1 = 1'b0;
            end
            OPC_SYSTEM: begin
                c.is_system = 1'b1; c.reg_write = (f3 != 3'b000);
                if (f3 == 3'b000 || f3[2]) c.has_rs1 = 1'b0;
            end
            OPC_FL: begin
                bad = !ENABLE_FP;
                c.reg_write = 1'b1; c.mem_read = 1'b1; c.is_load = 1'b1;
                c.has_imm = 1'b1; c.imm_type = IMM_I;
            end
            OPC_FS: begin
                bad = !ENABLE_FP;
                c.mem_write = 1'b1; c.is_store = 1'b1; c.has_rs2 = 1'b1;
                c.has_imm = 1'b1; c.imm_type = IMM_S;
            end
            OPC_FOTHER: begin
                bad = !ENABLE_FP;
                c.reg_write = 1'b1; c.alu_op = ALU_FP; c.has_rs2 = !inst[30];
            end
            OPC_FMADD, OPC_FMSUB, OPC_FNMSUB, OPC_FNMADD: begin
                bad = !ENABLE_FP;
                c.reg_write = 1'b1; c.alu_op = ALU_FP; c.has_rs2 = 1'b1; c.has_rs3 = ENABLE_FP;
            end
            default: bad = 1'b1;
        endcase
        if (inst[1:0] != 2'b11) bad = 1'b1;
        if (bad) begin
            c         = '0;
            c.illegal = 1'b1;
        end
    end

    assign ctrl = c;

endmodule

// File: rtl/decode_queue_ctrl.sv
// ID-stage decode queue: decodes at enqueue, buffers bundles, and issues to EX
// under load-use interlock, FENCE/SYSTEM serialisation and an illegal-instruction halt.
module decode_queue_ctrl
    import ctrl_pkg::*;
#(
    parameter int INST_WIDTH = 32,
    parameter int PC_WIDTH   = 32,
    parameter int BUF_DEPTH  = 2,
    parameter bit ENABLE_FP  = 1'b1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [INST_WIDTH-1:0] in_inst,
    input  logic [PC_WIDTH-1:0]   in_pc,
    input  logic                  flush,
    input  logic                  ex_load_valid,
    input  logic [4:0]            ex_load_rd,
    input  logic                  pipe_empty,
    output logic                  out_valid,
    input  logic                  out_ready,
    output ctrl_t                 out_ctrl,
    output logic [PC_WIDTH-1:0]   out_pc,
    output logic [INST_WIDTH-1:0] out_inst,
    output logic                  load_use_stall,
    output logic [CNT_WIDTH-1:0]  stall_cycles
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

    typedef struct packed {
        ctrl_t                 ctrl;
        logic [PC_WIDTH-1:0]   pc;
        logic [INST_WIDTH-1:0] inst;
    } entry_t;

    entry_t               mem [BUF_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]     count_reg;
    fsm_t                 state_reg, state_next;
    logic [CNT_WIDTH-1:0] stall_cnt_reg;
    ctrl_t                dec_ctrl;
    entry_t               head;
    logic                 head_valid, head_serial, hazard, push, pop;

    inst_decoder #(.INST_WIDTH(INST_WIDTH), .ENABLE_FP(ENABLE_FP)) u_dec (
        .inst (in_inst),
        .ctrl (dec_ctrl)
    );

    assign head        = mem[rd_ptr_reg];
    assign head_valid  = (count_reg != '0);
    assign head_serial = head.ctrl.is_system || head.ctrl.is_fence;
    // Register-index match only; int and FP files are deliberately not distinguished.
    assign hazard = head_valid && ex_load_valid && (ex_load_rd != 5'd0) &&
                    ((head.ctrl.has_rs1 && head.ctrl.rs1 == ex_load_rd) ||
                     (head.ctrl.has_rs2 && head.ctrl.rs2 == ex_load_rd) ||
                     (head.ctrl.has_rs3 && head.ctrl.rs3 == ex_load_rd));

    assign in_ready = (count_reg < DEPTH_C) && (state_reg != ST_HALT);
    assign push     = in_valid && in_ready && !flush;
    assign pop      = out_valid && out_ready && !flush;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= '{ctrl: dec_ctrl, pc: in_pc, inst: in_inst};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= ST_RUN;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RUN: begin
                if (pop && head.ctrl.illegal)           state_next = ST_HALT;
                else if (head_valid && head_serial && !pop) state_next = ST_SERIAL;
            end
            ST_SERIAL: if (pop) state_next = ST_RUN;
            ST_HALT:   state_next = ST_HALT;
            default:   state_next = ST_RUN;
        endcase
        if (flush) state_next = ST_RUN;
    end

    always_comb begin
        out_valid      = 1'b0;
        load_use_stall = 1'b0;
        if (head_valid && state_reg != ST_HALT) begin
            load_use_stall = hazard;
            out_valid      = !hazard && (!head_serial || pipe_empty);
        end
    end

    assign out_ctrl = head_valid ? head.ctrl : '0;
    assign out_pc   = head_valid ? head.pc   : '0;
    assign out_inst = head_valid ? head.inst : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                   stall_cnt_reg <= '0;
        else if (load_use_stall && stall_cnt_reg != '1) stall_cnt_reg <= stall_cnt_reg + CNT_WIDTH'(1);
    end

    assign stall_cycles = stall_cnt_reg;

endmodule

// File: tb/tb_decode_queue_ctrl.sv
// Self-checking bench: decode vector table, hand-written multi-cycle sequences,
// and a randomized run against a queue-level reference model.
module tb_decode_queue_ctrl;
    import ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst, in_valid, flush, ex_load_valid, pipe_empty, out_ready;
    logic [31:0] in_inst, in_pc;
    logic [4:0]  ex_load_rd;

    logic        in_ready, out_valid, load_use_stall;
    ctrl_t       out_ctrl;
    logic [31:0] out_pc, out_inst;
    logic [15:0] stall_cycles;

    logic        n_in_ready, n_out_valid, n_load_use_stall;
    ctrl_t       n_out_ctrl;
    logic [31:0] n_out_pc, n_out_inst;
    logic [1:0]  n_stall_cycles;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    decode_queue_ctrl dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
        .in_pc(in_pc), .flush(flush), .ex_load_valid(ex_load_valid), .ex_load_rd(ex_load_rd),
        .pipe_empty(pipe_empty), .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
        .out_pc(out_pc), .out_inst(out_inst), .load_use_stall(load_use_stall),
        .stall_cycles(stall_cycles)
    );

    decode_queue_ctrl #(.ENABLE_FP(1'b0), .CNT_WIDTH(2)) dut_nofp (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(n_in_ready), .in_inst(in_inst),
        .in_pc(in_pc), .flush(flush), .ex_load_valid(ex_load_valid), .ex_load_rd(ex_load_rd),
        .pipe_empty(pipe_empty), .out_valid(n_out_valid), .out_ready(out_ready), .out_ctrl(n_out_ctrl),
        .out_pc(n_out_pc), .out_inst(n_out_inst), .load_use_stall(n_load_use_stall),
        .stall_cycles(n_stall_cycles)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [31:0] inst, input logic [31:0] pc);
        in_inst = inst; in_pc = pc; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [31:0] inst;
        logic [3:0]  exp;        // {illegal, has_rs1, has_rs2, has_rs3}
        logic        nofp_ill;
    } vec_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        bit          u1, u2;
        logic [4:0]  r1, r2;
    } ment_t;

    vec_t        vt[20];
    ment_t       mq[$];
    logic [31:0] got[$];

    initial begin
        vt[0]  = '{32'h00500093, 4'b0100, 1'b0};
        vt[1]  = '{32'h006281B3, 4'b0110, 1'b0};
        vt[2]  = '{32'h403100B3, 4'b0110, 1'b0};
        vt[3]  = '{32'h40001033, 4'b1000, 1'b1};
        vt[4]  = '{32'h02000033, 4'b1000, 1'b1};
        vt[5]  = '{32'h40001013, 4'b1000, 1'b1};
        vt[6]  = '{32'h4030D093, 4'b0100, 1'b0};
        vt[7]  = '{32'h00000000, 4'b1000, 1'b1};
        vt[8]  = '{32'h123452B7, 4'b0000, 1'b0};
        vt[9]  = '{32'h0020A023, 4'b0110, 1'b0};
        vt[10] = '{32'h00208063, 4'b0110, 1'b0};
        vt[11] = '{32'h0FF0000F, 4'b0000, 1'b0};
        vt[12] = '{32'h00000073, 4'b0000, 1'b0};
        vt[13] = '{32'h300110F3, 4'b0100, 1'b0};
        vt[14] = '{32'h3002D0F3, 4'b0000, 1'b0};
        vt[15] = '{32'h203100C3, 4'b0111, 1'b1};
        vt[16] = '{32'h003100D3, 4'b0110, 1'b1};
        vt[17] = '{32'h580100D3, 4'b0100, 1'b1};
        vt[18] = '{32'h00500090, 4'b1000, 1'b1};
        vt[19] = '{32'h00012087, 4'b0100, 1'b1};

        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; ex_load_valid = 1'b0; ex_load_rd = 5'd0;
        pipe_empty = 1'b1; out_ready = 1'b0; in_inst = '0; in_pc = '0;
        #3;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_ctrl", out_ctrl, 0);
        check("rst_out_pc", out_pc, 0);
        check("rst_stall", load_use_stall, 0);
        check("rst_stall_cycles", stall_cycles, 0);
        tick();
        rst = 1'b0;

        // ADDI x1,x0,5: issuable the cycle after the push
        push1(32'h00500093, 32'h100);
        check("t1_out_valid", out_valid, 1);
        check("t1_alu_op", out_ctrl.alu_op, ALU_ADD);
        check("t1_has_imm", out_ctrl.has_imm, 1);
        check("t1_has_rs1", out_ctrl.has_rs1, 1);
        check("t1_has_rs2", out_ctrl.has_rs2, 0);
        check("t1_out_pc", out_pc, 32'h100);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t1_drained", out_valid, 0);

        // full queue backpressure and FIFO order
        push1(32'h00100093, 32'h200);
        check("t2_ready_after1", in_ready, 1);
        push1(32'h00200093, 32'h204);
        check("t2_ready_after2", in_ready, 0);
        in_inst = 32'h00300093; in_pc = 32'h208; in_valid = 1'b1;
        tick();
        check("t2_ready_held", in_ready, 0);
        check("t2_head_pc", out_pc, 32'h200);
        out_ready = 1'b1;
        got.delete();
        for (int cyc = 0; cyc < 10 && got.size() < 3; cyc++) begin
            logic acc;
            #1;
            if (out_valid) got.push_back(out_pc);
            acc = in_valid && in_ready;
            tick();
            if (acc) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        check("t2_count", got.size(), 3);
        for (int i = 0; i < got.size(); i++) check("t2_order", got[i], 32'h200 + 4 * i);
        out_ready = 1'b0;

        // load-use interlock and stall counter saturation (2-bit counter on dut_nofp)
        do_reset();
        ex_load_valid = 1'b1; ex_load_rd = 5'd5; out_ready = 1'b1;
        push1(32'h006281B3, 32'h300);
        for (int i = 0; i < 3; i++) begin
            check("t3_valid_low", out_valid, 0);
            check("t3_stall_high", load_use_stall, 1);
            tick();
        end
        check("t3_stall_cycles", stall_cycles, 3);
        check("t3_nofp_cycles", n_stall_cycles, 3);
        tick(); tick();
        check("t3_stall_cycles5", stall_cycles, 5);
        check("t3_nofp_saturate", n_stall_cycles, 3);
        ex_load_rd = 5'd0;
        #1;
        check("t3_rd0_valid", out_valid, 1);
        check("t3_rd0_nostall", load_use_stall, 0);
        tick();
        check("t3_cycles_hold", stall_cycles, 5);
        ex_load_valid = 1'b0;

        // FENCE serialisation
        pipe_empty = 1'b0;
        push1(32'h0FF0000F, 32'h400);
        for (int i = 0; i < 4; i++) begin
            check("t4_fence_held", out_valid, 0);
            tick();
        end
        pipe_empty = 1'b1;
        #1;
        check("t4_fence_issue", out_valid, 1);
        check("t4_fence_pc", out_pc, 32'h400);
        tick();
        check("t4_empty", out_valid, 0);
        pipe_empty = 1'b0;
        push1(32'h00500093, 32'h404);
        check("t4_back_to_run", out_valid, 1);
        tick();
        pipe_empty = 1'b1;

        // illegal entry issues, then halt; flush recovers and drops its own push
        push1(32'h00000000, 32'h500);
        check("t5_ill_valid", out_valid, 1);
        check("t5_ill_flag", out_ctrl.illegal, 1);
        check("t5_ill_regwrite", out_ctrl.reg_write, 0);
        tick();
        check("t5_halt_ready", in_ready, 0);
        check("t5_halt_valid", out_valid, 0);
        in_inst = 32'h00500093; in_pc = 32'h504; in_valid = 1'b1; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        #1;
        check("t5_flush_ready", in_ready, 1);
        check("t5_flush_empty", out_valid, 0);
        check("t5_cnt_not_flushed", stall_cycles, 5);

        // asynchronous reset mid-operation
        out_ready = 1'b0;
        push1(32'h00500093, 32'h600);
        rst = 1'b1;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_cycles", stall_cycles, 0);
        check("arst_pc", out_pc, 0);
        tick();
        rst = 1'b0;

        // decode vector table
        for (int i = 0; i < 20; i++) begin
            do_flush();
            push1(vt[i].inst, 32'h1000 + 4 * i);
            check("vec_fields", {out_ctrl.illegal, out_ctrl.has_rs1, out_ctrl.has_rs2,
                                 out_ctrl.has_rs3}, vt[i].exp);
            check("vec_nofp_illegal", n_out_ctrl.illegal, vt[i].nofp_ill);
            $display("vec %0d inst=%08h fields=%b nofp_ill=%b", i, vt[i].inst,
                     {out_ctrl.illegal, out_ctrl.has_rs1, out_ctrl.has_rs2, out_ctrl.has_rs3},
                     n_out_ctrl.illegal);
        end

        // randomized traffic against a queue-level model
        do_reset();
        begin
            int          cnt_model;
            logic [31:0] pc_seq;
            cnt_model = 0;
            pc_seq = 32'h8000;
            mq.delete();
            for (int cyc = 0; cyc < 400; cyc++) begin
                ment_t       e;
                logic [4:0]  rd, r1, r2;
                bit          exp_ready, haz, exp_valid;
                int          form;
                in_valid      = 1'($urandom_range(0, 1));
                out_ready     = ($urandom_range(0, 3) != 0);
                ex_load_valid = 1'($urandom_range(0, 1));
                ex_load_rd    = 5'($urandom_range(0, 3));
                rd = 5'($urandom_range(0, 3));
                r1 = 5'($urandom_range(0, 3));
                r2 = 5'($urandom_range(0, 3));
                form = $urandom_range(0, 5);
                e.pc = pc_seq; e.r1 = r1; e.r2 = r2;
                case (form)
                    0: begin e.inst = {7'h00, r2, r1, 3'b000, rd, 7'b0110011}; e.u1 = 1; e.u2 = 1; end
                    1: begin e.inst = {7'h20, r2, r1, 3'b000, rd, 7'b0110011}; e.u1 = 1; e.u2 = 1; end
                    2: begin e.inst = {12'(cyc), r1, 3'b000, rd, 7'b0010011}; e.u1 = 1; e.u2 = 0; end
                    3: begin e.inst = {20'(cyc), rd, 7'b0110111}; e.u1 = 0; e.u2 = 0; end
                    4: begin e.inst = {7'h00, r2, r1, 3'b010, 5'd0, 7'b0100011}; e.u1 = 1; e.u2 = 1; end
                    default: begin e.inst = {12'h0, r1, 3'b010, rd, 7'b0000011}; e.u1 = 1; e.u2 = 0; end
                endcase
                in_inst = e.inst; in_pc = e.pc;
                #1;
                exp_ready = (mq.size() < 2);
                haz = (mq.size() > 0) && ex_load_valid && (ex_load_rd != 0) &&
                      ((mq[0].u1 && mq[0].r1 == ex_load_rd) || (mq[0].u2 && mq[0].r2 == ex_load_rd));
                exp_valid = (mq.size() > 0) && !haz;
                check("rnd_in_ready", in_ready, exp_ready);
                check("rnd_out_valid", out_valid, exp_valid);
                check("rnd_stall", load_use_stall, haz);
                check("rnd_stall_cycles", stall_cycles, cnt_model);
                if (exp_valid) begin
                    check("rnd_out_pc", out_pc, mq[0].pc);
                    check("rnd_out_inst", out_inst, mq[0].inst);
                end
                if (exp_valid && out_ready) begin
                    $display("issue pc=%08h inst=%08h", mq[0].pc, mq[0].inst);
                    void'(mq.pop_front());
                end
                if (in_valid && exp_ready) begin
                    mq.push_back(e);
                    pc_seq = pc_seq + 4;
                end
                if (haz && cnt_model != 16'hFFFF) cnt_model++;
                tick();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
